// File: rtl/tetris_grid_renderer.sv
// Double-buffered 10x20 Tetris playfield renderer: shadow rows from the game FSM are
// copied to the display buffer at frame start, and a 2-stage pixel pipeline emits RGB.
module tetris_grid_renderer #(
  parameter int          GRID_X0    = 240,
  parameter int          GRID_Y0    = 80,
  parameter int          CELL_LOG2  = 4,
  parameter int          BORDER_W   = 4,
  parameter logic [11:0] C_FILLED   = 12'hF80,
  parameter logic [11:0] C_EMPTY    = 12'h111,
  parameter logic [11:0] C_GRIDLINE = 12'h333,
  parameter logic [11:0] C_BORDER   = 12'hFFF,
  parameter logic [11:0] C_BG       = 12'h000,
  parameter logic [11:0] C_OVER     = 12'hF00
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_grid_we,
  input  logic [4:0]  i_grid_address,
  input  logic [9:0]  i_grid_line_data,
  input  logic [3:0]  i_c_state,
  input  logic        i_frame_start,
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic        i_de,
  output logic [11:0] o_rgb,
  output logic        o_de,
  output logic        o_copy_busy
);

  localparam int GRID_COLS = 10;
  localparam int GRID_ROWS = 20;
  localparam logic signed [11:0] X0_S     = 12'(GRID_X0);
  localparam logic signed [11:0] Y0_S     = 12'(GRID_Y0);
  localparam logic signed [11:0] GRID_W_S = 12'(GRID_COLS << CELL_LOG2);
  localparam logic signed [11:0] GRID_H_S = 12'(GRID_ROWS << CELL_LOG2);
  localparam logic signed [11:0] BW_S     = 12'(BORDER_W);
  localparam logic [3:0]         GAME_OVER_STATE = 4'b1000;

  typedef enum logic {IDLE, COPY} state_t;

  logic [GRID_COLS-1:0] shadow_q  [GRID_ROWS];
  logic [GRID_COLS-1:0] display_q [GRID_ROWS];

  state_t     state_q, state_d;
  logic [4:0] copy_row_q, copy_row_d;
  logic       copy_en;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    copy_row_d = copy_row_q;
    copy_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          state_d    = COPY;
          copy_row_d = '0;
        end
      end
      COPY: begin
        copy_en = 1'b1;
        if (copy_row_q == 5'(GRID_ROWS - 1)) begin
          state_d    = IDLE;
          copy_row_d = '0;
        end else begin
          copy_row_d = copy_row_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      copy_row_q <= '0;
    end else begin
      state_q    <= state_d;
      copy_row_q <= copy_row_d;
    end
  end

  assign o_copy_busy = (state_q == COPY);

  // NOTE: both buffers are small register arrays, so clearing them in reset is cheap and guarantees an empty board after reset.
  // Non-blocking reads of shadow_q give the copy the pre-write value on a same-row collision.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      for (int r = 0; r < GRID_ROWS; r++) begin
        shadow_q[r]  <= '0;
        display_q[r] <= '0;
      end
    end else begin
      if (i_grid_we && (i_grid_address <= 5'(GRID_ROWS - 1)))
        shadow_q[i_grid_address] <= i_grid_line_data;
      if (copy_en)
        display_q[copy_row_q] <= shadow_q[copy_row_q];
    end
  end

  // Stage 1: geometry of the current pixel relative to the playfield.
  logic signed [11:0] dx, dy;
  logic       in_grid_d, in_border_d, edge_d;
  logic [3:0] col_d;
  logic [4:0] row_d;

  assign dx = $signed({1'b0, i_hcount}) - X0_S;
  assign dy = $signed({1'b0, i_vcount}) - Y0_S;

  always_comb begin
    in_grid_d   = (dx >= 12'sd0) && (dx < GRID_W_S) && (dy >= 12'sd0) && (dy < GRID_H_S);
    in_border_d = (dx >= -BW_S) && (dx < GRID_W_S + BW_S) &&
                  (dy >= -BW_S) && (dy < GRID_H_S + BW_S) && !in_grid_d;
    col_d       = 4'(dx >>> CELL_LOG2);
    row_d       = 5'(dy >>> CELL_LOG2);
    edge_d      = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
  end

  logic       in_grid_q, in_border_q, edge_q, de1_q;
  logic [3:0] col_q;
  logic [4:0] row_q;
  logic [11:0] rgb_d, rgb_q;
  logic        de2_q;

  // Stage 2: colour priority; the cell lookup is only trusted inside the grid.
  always_comb begin
    rgb_d = C_BG;
    if (!de1_q) begin
      rgb_d = 12'h000;
    end else if (in_grid_q) begin
      if (display_q[row_q][col_q])
        rgb_d = (i_c_state == GAME_OVER_STATE) ? C_OVER : C_FILLED;
      else if (edge_q)
        rgb_d = C_GRIDLINE;
      else
        rgb_d = C_EMPTY;
    end else if (in_border_q) begin
      rgb_d = C_BORDER;
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      in_grid_q   <= 1'b0;
      in_border_q <= 1'b0;
      edge_q      <= 1'b0;
      de1_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      rgb_q       <= '0;
      de2_q       <= 1'b0;
    end else begin
      in_grid_q   <= in_grid_d;
      in_border_q <= in_border_d;
      edge_q      <= edge_d;
      de1_q       <= i_de;
      col_q       <= col_d;
      row_q       <= row_d;
      rgb_q       <= rgb_d;
      de2_q       <= de1_q;
    end
  end

  assign o_rgb = rgb_q;
  assign o_de  = de2_q;

endmodule
